// File: rtl/m_sequence_pkg.sv
// Shared constants and helpers for the m-sequence generator family:
// default primitive Galois tap masks and the maximal period length.
package m_sequence_pkg;

    localparam logic [1:0]  TAPS_2  = 2'h3;
    localparam logic [2:0]  TAPS_3  = 3'h6;
    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [4:0]  TAPS_5  = 5'h14;
    localparam logic [5:0]  TAPS_6  = 6'h30;
    localparam logic [6:0]  TAPS_7  = 7'h60;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [8:0]  TAPS_9  = 9'h110;
    localparam logic [9:0]  TAPS_10 = 10'h240;
    localparam logic [10:0] TAPS_11 = 11'h500;
    localparam logic [11:0] TAPS_12 = 12'h829;
    localparam logic [12:0] TAPS_13 = 13'h100D;
    localparam logic [13:0] TAPS_14 = 14'h2015;
    localparam logic [14:0] TAPS_15 = 15'h6000;
    localparam logic [15:0] TAPS_16 = 16'hD008;
    localparam logic [16:0] TAPS_17 = 17'h12000;
    localparam logic [17:0] TAPS_18 = 18'h20400;
    localparam logic [18:0] TAPS_19 = 19'h40023;
    localparam logic [19:0] TAPS_20 = 20'h90000;
    localparam logic [20:0] TAPS_21 = 21'h140000;
    localparam logic [21:0] TAPS_22 = 22'h300000;
    localparam logic [22:0] TAPS_23 = 23'h420000;
    localparam logic [23:0] TAPS_24 = 24'hE10000;
    localparam logic [24:0] TAPS_25 = 25'h1200000;
    localparam logic [25:0] TAPS_26 = 26'h2000023;
    localparam logic [26:0] TAPS_27 = 27'h4000013;
    localparam logic [27:0] TAPS_28 = 28'h9000000;
    localparam logic [28:0] TAPS_29 = 29'h14000000;
    localparam logic [29:0] TAPS_30 = 30'h20000029;
    localparam logic [30:0] TAPS_31 = 31'h48000000;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    function automatic logic [32:0] period_len(input int width);
        return 33'((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [31:0] default_taps(input int width);
        case (width)
            2:       return 32'(TAPS_2);
            3:       return 32'(TAPS_3);
            4:       return 32'(TAPS_4);
            5:       return 32'(TAPS_5);
            6:       return 32'(TAPS_6);
            7:       return 32'(TAPS_7);
            8:       return 32'(TAPS_8);
            9:       return 32'(TAPS_9);
            10:      return 32'(TAPS_10);
            11:      return 32'(TAPS_11);
            12:      return 32'(TAPS_12);
            13:      return 32'(TAPS_13);
            14:      return 32'(TAPS_14);
            15:      return 32'(TAPS_15);
            16:      return 32'(TAPS_16);
            17:      return 32'(TAPS_17);
            18:      return 32'(TAPS_18);
            19:      return 32'(TAPS_19);
            20:      return 32'(TAPS_20);
            21:      return 32'(TAPS_21);
            22:      return 32'(TAPS_22);
            23:      return 32'(TAPS_23);
            24:      return 32'(TAPS_24);
            25:      return 32'(TAPS_25);
            26:      return 32'(TAPS_26);
            27:      return 32'(TAPS_27);
            28:      return 32'(TAPS_28);
            29:      return 32'(TAPS_29);
            30:      return 32'(TAPS_30);
            31:      return 32'(TAPS_31);
            32:      return 32'(TAPS_32);
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/m_sequence_word_packer.sv
// Packs emitted sequence bits LSB-first into WORD_W-bit words and
// pulses o_word_valid for one cycle when a word completes.
module m_sequence_word_packer #(
    parameter int WORD_W = 8
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic              i_bit,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid
);

    localparam int CW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_sr;
    logic [WORD_W-1:0] r_word;
    logic [CW-1:0]     r_cnt;
    logic              r_valid;
    logic [WORD_W-1:0] w_sr_next;
    logic              w_last;

    // New bits enter at the MSB so the oldest bit lands at bit 0.
    generate
        if (WORD_W == 1) begin : g_one
            assign w_sr_next = i_bit;
        end else begin : g_many
            assign w_sr_next = {i_bit, r_sr[WORD_W-1:1]};
        end
    endgenerate

    assign w_last = (r_cnt == CW'(WORD_W - 1));

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_sr    <= '0;
            r_word  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_step) begin
                r_sr <= w_sr_next;
                if (w_last) begin
                    r_cnt   <= '0;
                    r_word  <= w_sr_next;
                    r_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_valid;

endmodule

// File: rtl/m_sequence_gen.sv
// Galois LFSR m-sequence generator with seed/tap loading and lock-up
// recovery. Define M_SEQ_PERIOD_CHECK_EN to build the period checker.
module m_sequence_gen
    import m_sequence_pkg::*;
#(
    parameter int               WIDTH  = 4,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(3),
    parameter int               WORD_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_seed,
    input  logic [WIDTH-1:0]  load_taps,
    output logic              out,
    output logic [WIDTH-1:0]  state,
    output logic              sync,
    output logic              lockup,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic              period_error
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_taps;
    logic             r_lockup;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_ld_seed;
    logic             w_zero;
    logic             w_step;
    logic             w_sync;

    assign w_zero    = (r_state == '0);
    assign w_ld_seed = (load_seed == '0) ? SEED : load_seed;
    assign w_step    = enable & ~load & ~w_zero;
    assign w_next    = (r_state >> 1) ^ (r_state[0] ? r_taps : '0);
    assign w_sync    = enable & (r_state == r_seed);

    // Priority: reset, load, all-zero recovery, then a normal step.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= SEED;
            r_seed   <= SEED;
            r_taps   <= TAPS;
            r_lockup <= 1'b0;
        end else if (load) begin
            r_state  <= w_ld_seed;
            r_seed   <= w_ld_seed;
            r_taps   <= load_taps;
            r_lockup <= (load_seed == '0);
        end else if (w_zero) begin
            r_state  <= r_seed;
            r_lockup <= 1'b1;
        end else begin
            r_lockup <= 1'b0;
            if (enable) begin
                r_state <= w_next;
            end
        end
    end

    m_sequence_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .i_clock      (clock),
        .i_reset_n    (reset),
        .i_clear      (load),
        .i_step       (w_step),
        .i_bit        (r_state[0]),
        .o_word       (word),
        .o_word_valid (word_valid)
    );

`ifdef M_SEQ_PERIOD_CHECK_EN
    logic [32:0] r_pcnt;
    logic        r_seen;
    logic        r_perr;

    // The count includes the step taken in the sync cycle itself.
    always_ff @(posedge clock) begin
        if (!reset || load) begin
            r_pcnt <= '0;
            r_seen <= 1'b0;
            r_perr <= 1'b0;
        end else if (w_step) begin
            if (w_sync) begin
                if (r_seen && (r_pcnt != period_len(WIDTH))) begin
                    r_perr <= 1'b1;
                end
                r_seen <= 1'b1;
                r_pcnt <= 33'd1;
            end else begin
                r_pcnt <= r_pcnt + 33'd1;
            end
        end
    end

    assign period_error = r_perr;
`else
    assign period_error = 1'b0;
`endif

    assign out    = r_state[0];
    assign state  = r_state;
    assign sync   = w_sync;
    assign lockup = r_lockup;

endmodule
